// File: rtl/id_stage.sv
// ----------------------------------------------------------------------------
// id_stage: MIPS instruction-decode stage.
// Holds the 32x32 register file (written from WB), decodes the IF/ID
// instruction into ID/EX control/data fields and flags load-use hazards.
// All outputs are combinational; the register file is the only state.
// ----------------------------------------------------------------------------
module id_stage #(
    parameter int BYPASS = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr_ID,
    input  logic        flush_ID,
    input  logic        regwrite_WB,
    input  logic [4:0]  writereg_WB,
    input  logic [31:0] result_WB,
    input  logic        memtoreg_EX,
    input  logic [4:0]  rt_EX,
    output logic        memtoreg_ID,
    output logic        memwrite_ID,
    output logic        alusrc_ID,
    output logic        regdst_ID,
    output logic        regwrite_ID,
    output logic        branch_ID,
    output logic [2:0]  alucontrol_ID,
    output logic [31:0] rs_data_ID,
    output logic [31:0] rt_data_ID,
    output logic [31:0] signext_ID,
    output logic [4:0]  rs_ID,
    output logic [4:0]  rt_ID,
    output logic [4:0]  rd_ID,
    output logic        stall
);

    localparam bit BYP_EN = (BYPASS != 0);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_SLT   = 6'b101010;

    logic [31:0] regs_r [32];
    logic        wr_en_s;
    logic [5:0]  opcode_s;
    logic [5:0]  funct_s;

    logic        memtoreg_s;
    logic        memwrite_s;
    logic        alusrc_s;
    logic        regdst_s;
    logic        regwrite_s;
    logic        branch_s;
    logic [2:0]  alucontrol_s;

    // Instruction fields; r0 is never written so its entry stays zero.
    assign opcode_s   = instr_ID[31:26];
    assign funct_s    = instr_ID[5:0];
    assign rs_ID      = instr_ID[25:21];
    assign rt_ID      = instr_ID[20:16];
    assign rd_ID      = instr_ID[15:11];
    assign signext_ID = {{16{instr_ID[15]}}, instr_ID[15:0]};

    // Writes to r0 are dropped; reset also blocks the write path.
    assign wr_en_s = regwrite_WB && (writereg_WB != 5'd0) && !reset;

    // Register file storage: async clear, write on rising edge from WB.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                regs_r[i] <= 32'd0;
            end
        end else if (wr_en_s) begin
            regs_r[writereg_WB] <= result_WB;
        end
    end

    // rs read port: zero under reset or for r0, optional same-cycle WB bypass.
    always_comb begin
        rs_data_ID = 32'd0;
        if (reset) begin
            rs_data_ID = 32'd0;
        end else if (BYP_EN && wr_en_s && (writereg_WB == rs_ID)) begin
            rs_data_ID = result_WB;
        end else if (rs_ID == 5'd0) begin
            rs_data_ID = 32'd0;
        end else begin
            rs_data_ID = regs_r[rs_ID];
        end
    end

    // rt read port: same policy as the rs port.
    always_comb begin
        rt_data_ID = 32'd0;
        if (reset) begin
            rt_data_ID = 32'd0;
        end else if (BYP_EN && wr_en_s && (writereg_WB == rt_ID)) begin
            rt_data_ID = result_WB;
        end else if (rt_ID == 5'd0) begin
            rt_data_ID = 32'd0;
        end else begin
            rt_data_ID = regs_r[rt_ID];
        end
    end

    // Main decoder: opcode/funct to raw control set (unknown encodings are nops).
    always_comb begin
        memtoreg_s   = 1'b0;
        memwrite_s   = 1'b0;
        alusrc_s     = 1'b0;
        regdst_s     = 1'b0;
        regwrite_s   = 1'b0;
        branch_s     = 1'b0;
        alucontrol_s = 3'b000;
        case (opcode_s)
            OP_RTYPE: begin
                case (funct_s)
                    FN_ADD: begin
                        regwrite_s   = 1'b1;
                        regdst_s     = 1'b1;
                        alucontrol_s = 3'b010;
                    end
                    FN_SUB: begin
                        regwrite_s   = 1'b1;
                        regdst_s     = 1'b1;
                        alucontrol_s = 3'b110;
                    end
                    FN_AND: begin
                        regwrite_s   = 1'b1;
                        regdst_s     = 1'b1;
                        alucontrol_s = 3'b000;
                    end
                    FN_OR: begin
                        regwrite_s   = 1'b1;
                        regdst_s     = 1'b1;
                        alucontrol_s = 3'b001;
                    end
                    FN_SLT: begin
                        regwrite_s   = 1'b1;
                        regdst_s     = 1'b1;
                        alucontrol_s = 3'b111;
                    end
                    default: begin
                        regwrite_s   = 1'b0;
                        regdst_s     = 1'b0;
                        alucontrol_s = 3'b000;
                    end
                endcase
            end
            OP_LW: begin
                regwrite_s   = 1'b1;
                alusrc_s     = 1'b1;
                memtoreg_s   = 1'b1;
                alucontrol_s = 3'b010;
            end
            OP_SW: begin
                memwrite_s   = 1'b1;
                alusrc_s     = 1'b1;
                alucontrol_s = 3'b010;
            end
            OP_BEQ: begin
                branch_s     = 1'b1;
                alucontrol_s = 3'b110;
            end
            OP_ADDI: begin
                regwrite_s   = 1'b1;
                alusrc_s     = 1'b1;
                alucontrol_s = 3'b010;
            end
            default: begin
                alucontrol_s = 3'b000;
            end
        endcase
    end

    // Flush squashes the ID instruction by zeroing every control output.
    always_comb begin
        memtoreg_ID   = 1'b0;
        memwrite_ID   = 1'b0;
        alusrc_ID     = 1'b0;
        regdst_ID     = 1'b0;
        regwrite_ID   = 1'b0;
        branch_ID     = 1'b0;
        alucontrol_ID = 3'b000;
        if (flush_ID) begin
            alucontrol_ID = 3'b000;
        end else begin
            memtoreg_ID   = memtoreg_s;
            memwrite_ID   = memwrite_s;
            alusrc_ID     = alusrc_s;
            regdst_ID     = regdst_s;
            regwrite_ID   = regwrite_s;
            branch_ID     = branch_s;
            alucontrol_ID = alucontrol_s;
        end
    end

    // Load-use hazard; rt is compared for every opcode, flush overrides.
    always_comb begin
        stall = 1'b0;
        if (memtoreg_EX && (rt_EX != 5'd0) && !flush_ID &&
            ((rt_EX == rs_ID) || (rt_EX == rt_ID))) begin
            stall = 1'b1;
        end else begin
            stall = 1'b0;
        end
    end

endmodule

// File: tb/tb_id_stage.sv
// ----------------------------------------------------------------------------
// tb_id_stage: directed bench for id_stage, one instance per BYPASS setting
// sharing the same inputs.
// ----------------------------------------------------------------------------
module tb_id_stage;

    logic        clk;
    logic        reset;
    logic [31:0] instr_ID;
    logic        flush_ID;
    logic        regwrite_WB;
    logic [4:0]  writereg_WB;
    logic [31:0] result_WB;
    logic        memtoreg_EX;
    logic [4:0]  rt_EX;

    logic        memtoreg_a, memwrite_a, alusrc_a, regdst_a, regwrite_a, branch_a, stall_a;
    logic [2:0]  aluctl_a;
    logic [31:0] rsd_a, rtd_a, sext_a;
    logic [4:0]  rs_a, rt_a, rd_a;

    logic        memtoreg_b, memwrite_b, alusrc_b, regdst_b, regwrite_b, branch_b, stall_b;
    logic [2:0]  aluctl_b;
    logic [31:0] rsd_b, rtd_b, sext_b;
    logic [4:0]  rs_b, rt_b, rd_b;

    int total = 0;
    int bad   = 0;

    logic [8:0] ctl_a;
    assign ctl_a = {memtoreg_a, memwrite_a, alusrc_a, regdst_a, regwrite_a, branch_a, aluctl_a};

    id_stage #(.BYPASS(1)) u_a (
        .clk(clk), .reset(reset), .instr_ID(instr_ID), .flush_ID(flush_ID),
        .regwrite_WB(regwrite_WB), .writereg_WB(writereg_WB), .result_WB(result_WB),
        .memtoreg_EX(memtoreg_EX), .rt_EX(rt_EX),
        .memtoreg_ID(memtoreg_a), .memwrite_ID(memwrite_a), .alusrc_ID(alusrc_a),
        .regdst_ID(regdst_a), .regwrite_ID(regwrite_a), .branch_ID(branch_a),
        .alucontrol_ID(aluctl_a), .rs_data_ID(rsd_a), .rt_data_ID(rtd_a),
        .signext_ID(sext_a), .rs_ID(rs_a), .rt_ID(rt_a), .rd_ID(rd_a), .stall(stall_a)
    );

    id_stage #(.BYPASS(0)) u_b (
        .clk(clk), .reset(reset), .instr_ID(instr_ID), .flush_ID(flush_ID),
        .regwrite_WB(regwrite_WB), .writereg_WB(writereg_WB), .result_WB(result_WB),
        .memtoreg_EX(memtoreg_EX), .rt_EX(rt_EX),
        .memtoreg_ID(memtoreg_b), .memwrite_ID(memwrite_b), .alusrc_ID(alusrc_b),
        .regdst_ID(regdst_b), .regwrite_ID(regwrite_b), .branch_ID(branch_b),
        .alucontrol_ID(aluctl_b), .rs_data_ID(rsd_b), .rt_data_ID(rtd_b),
        .signext_ID(sext_b), .rs_ID(rs_b), .rt_ID(rt_b), .rd_ID(rd_b), .stall(stall_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive a WB write from the falling edge; caller checks before the edge.
    task automatic setup_write(input logic [4:0] addr, input logic [31:0] data);
        @(negedge clk);
        regwrite_WB = 1'b1;
        writereg_WB = addr;
        result_WB   = data;
    endtask

    task automatic finish_write();
        @(posedge clk);
        #1;
        regwrite_WB = 1'b0;
        writereg_WB = 5'd0;
        result_WB   = 32'd0;
        #1;
    endtask

    initial begin
        reset       = 1'b1;
        instr_ID    = 32'd0;
        flush_ID    = 1'b0;
        regwrite_WB = 1'b0;
        writereg_WB = 5'd0;
        result_WB   = 32'd0;
        memtoreg_EX = 1'b0;
        rt_EX       = 5'd0;
        #2;
        // Under reset with instr 0, everything is zero.
        chk("rst_ctl", {23'd0, ctl_a}, 32'd0);
        chk("rst_stall", {31'd0, stall_a}, 32'd0);
        chk("rst_sext", sext_a, 32'd0);
        chk("rst_rsd", rsd_a, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // All 32 registers read zero after reset, on both ports and both instances.
        for (int i = 0; i < 32; i++) begin
            instr_ID = {6'd0, 5'(i), 5'(31 - i), 16'd0};
            #1;
            chk("init_rs_a", rsd_a, 32'd0);
            chk("init_rt_a", rtd_a, 32'd0);
            chk("init_rs_b", rsd_b, 32'd0);
            chk("init_rt_b", rtd_b, 32'd0);
        end

        // r5 write, then reset asserted mid-write.
        instr_ID = {6'd0, 5'd5, 5'd5, 16'd0};
        setup_write(5'd5, 32'hDEADBEEF);
        #1;
        chk("r5_byp", rsd_a, 32'hDEADBEEF);
        chk("r5_nobyp", rsd_b, 32'd0);
        reset = 1'b1;
        #1;
        chk("r5_rst_a", rsd_a, 32'd0);
        chk("r5_rst_at", rtd_a, 32'd0);
        @(posedge clk);
        #1;
        chk("r5_rst_edge_a", rsd_a, 32'd0);
        chk("r5_rst_edge_b", rsd_b, 32'd0);
        regwrite_WB = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("r5_post_a", rsd_a, 32'd0);
        chk("r5_post_b", rsd_b, 32'd0);

        // r7 write with bypass visible before edge only on BYPASS=1.
        instr_ID = {6'd0, 5'd7, 5'd0, 16'd0};
        setup_write(5'd7, 32'h12345678);
        #1;
        chk("r7_pre_a", rsd_a, 32'h12345678);
        chk("r7_pre_b", rsd_b, 32'd0);
        finish_write();
        chk("r7_post_a", rsd_a, 32'h12345678);
        chk("r7_post_b", rsd_b, 32'h12345678);

        // r0 write is ignored.
        instr_ID = {6'd0, 5'd0, 5'd0, 16'd0};
        setup_write(5'd0, 32'hFFFFFFFF);
        #1;
        chk("r0_pre_a", rsd_a, 32'd0);
        chk("r0_pre_bt", rtd_b, 32'd0);
        finish_write();
        chk("r0_post_a", rsd_a, 32'd0);
        chk("r0_post_b", rtd_b, 32'd0);

        // r2 value used later to prove data survives a flush.
        setup_write(5'd2, 32'hCAFE0002);
        finish_write();

        // lw $5,4($2)
        instr_ID = 32'h8C450004;
        #1;
        chk("lw_ctl", {23'd0, ctl_a}, {23'd0, 9'b101010010});
        chk("lw_rs", {27'd0, rs_a}, 32'd2);
        chk("lw_rt", {27'd0, rt_a}, 32'd5);
        chk("lw_rd", {27'd0, rd_a}, 32'd0);
        chk("lw_sext", sext_a, 32'h00000004);
        chk("lw_rsd", rsd_a, 32'hCAFE0002);

        // addi with negative immediate
        instr_ID = 32'h2002FFFF;
        #1;
        chk("addi_ctl", {23'd0, ctl_a}, {23'd0, 9'b001010010});
        chk("addi_sext", sext_a, 32'hFFFFFFFF);

        // sub $1,$2,$3
        instr_ID = 32'h00430822;
        #1;
        chk("sub_ctl", {23'd0, ctl_a}, {23'd0, 9'b000110110});
        chk("sub_rd", {27'd0, rd_a}, 32'd1);

        // slt, and, or, unknown funct, sw, beq
        instr_ID = 32'h0043082A;
        #1;
        chk("slt_ctl", {23'd0, ctl_a}, {23'd0, 9'b000110111});
        instr_ID = 32'h00430824;
        #1;
        chk("and_ctl", {23'd0, ctl_a}, {23'd0, 9'b000110000});
        instr_ID = 32'h00430825;
        #1;
        chk("or_ctl", {23'd0, ctl_a}, {23'd0, 9'b000110001});
        instr_ID = 32'h00430821;
        #1;
        chk("rbad_ctl", {23'd0, ctl_a}, 32'd0);
        instr_ID = 32'hAC450000;
        #1;
        chk("sw_ctl", {23'd0, ctl_a}, {23'd0, 9'b011000010});
        instr_ID = 32'h10430001;
        #1;
        chk("beq_ctl", {23'd0, ctl_a}, {23'd0, 9'b000001110});

        // nop and unknown opcode
        instr_ID = 32'h00000000;
        #1;
        chk("nop_ctl", {23'd0, ctl_a}, 32'd0);
        instr_ID = 32'hFC000000;
        #1;
        chk("op3f_ctl", {23'd0, ctl_a}, 32'd0);

        // Load-use hazard on rs, controls not zeroed by stall.
        memtoreg_EX = 1'b1;
        rt_EX       = 5'd5;
        instr_ID    = 32'h00A60820;
        #1;
        chk("haz_rs", {31'd0, stall_a}, 32'd1);
        chk("haz_ctl", {23'd0, ctl_a}, {23'd0, 9'b000110010});
        flush_ID = 1'b1;
        #1;
        chk("haz_flush", {31'd0, stall_a}, 32'd0);
        chk("haz_flush_ctl", {23'd0, ctl_a}, 32'd0);
        flush_ID = 1'b0;
        rt_EX    = 5'd0;
        #1;
        chk("haz_rt0", {31'd0, stall_a}, 32'd0);
        rt_EX = 5'd6;
        #1;
        chk("haz_rt", {31'd0, stall_b}, 32'd1);
        rt_EX = 5'd9;
        #1;
        chk("haz_nomatch", {31'd0, stall_a}, 32'd0);
        rt_EX       = 5'd5;
        memtoreg_EX = 1'b0;
        #1;
        chk("haz_noload", {31'd0, stall_a}, 32'd0);

        // Flushed sw keeps fields and read data.
        flush_ID = 1'b1;
        instr_ID = 32'hAC450000;
        #1;
        chk("fl_memwrite", {31'd0, memwrite_a}, 32'd0);
        chk("fl_ctl", {23'd0, ctl_a}, 32'd0);
        chk("fl_rs", {27'd0, rs_a}, 32'd2);
        chk("fl_rt", {27'd0, rt_a}, 32'd5);
        chk("fl_rsd", rsd_a, 32'hCAFE0002);
        chk("fl_rsd_b", rsd_b, 32'hCAFE0002);
        chk("fl_sext", sext_a, 32'd0);
        flush_ID = 1'b0;

        // Reset clears r7 and r2; controls still follow instr under reset.
        @(negedge clk);
        reset    = 1'b1;
        instr_ID = 32'h00E20822;
        #1;
        chk("rst2_rsd", rsd_a, 32'd0);
        chk("rst2_ctl", {23'd0, ctl_a}, {23'd0, 9'b000110110});
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst2_r7", rsd_b, 32'd0);
        chk("rst2_r2", rtd_b, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
